// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [31:0] NOP_INSN = 32'h00007013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    REDIRECT = 2'd2
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the EX-stage load destination and the ID-stage sources.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  output logic                 load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it can never create a dependency.
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush decisions for PC, IF/ID and ID/EX.
// Optional perf counters (o_stall_cnt, o_flush_cnt) are built when HAZARD_PERF_CNT_EN is defined.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue; branch, mul/div, load-use, fetch checks
//   MD_WAIT  | pipeline frozen until the mul/div unit reports done
//   REDIRECT | first cycle after a taken branch; IF/ID forced to NOP
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_use_rs1,
  input  logic                 i_id_use_rs2,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_is_load,
  input  logic                 i_ex_br_taken,
  input  logic                 i_ex_md_req,
  input  logic                 i_md_done,
  input  logic                 i_imem_valid,
  output logic                 o_pc_we,
  output logic                 o_ifid_we,
  output logic                 o_ifid_flush,
  output logic                 o_idex_we,
  output logic                 o_idex_flush,
  output logic                 o_stall
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]          o_stall_cnt,
  output logic [31:0]          o_flush_cnt
`endif
);

  hz_state_e state;
  hz_state_e state_nxt;
  logic      load_use;

  hazard_detect u_hazard_detect (
    .id_rs1     (i_id_rs1),
    .id_rs2     (i_id_rs2),
    .id_use_rs1 (i_id_use_rs1),
    .id_use_rs2 (i_id_use_rs2),
    .ex_rd      (i_ex_rd),
    .ex_is_load (i_ex_is_load),
    .load_use   (load_use)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) state <= RUN;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = RUN;
    o_pc_we      = 1'b1;
    o_ifid_we    = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_we    = 1'b1;
    o_idex_flush = 1'b0;

    if (state == MD_WAIT) begin
      // Redirects are ignored here; the branch is still held in EX behind the mul/div.
      if (!i_md_done) begin
        state_nxt = MD_WAIT;
        o_pc_we   = 1'b0;
        o_ifid_we = 1'b0;
        o_idex_we = 1'b0;
      end
    end else begin
      if (i_ex_br_taken) begin
        state_nxt    = REDIRECT;
        o_ifid_flush = 1'b1;
        o_idex_flush = 1'b1;
      end else if (i_ex_md_req && !i_md_done) begin
        state_nxt = MD_WAIT;
        o_pc_we   = 1'b0;
        o_ifid_we = 1'b0;
        o_idex_we = 1'b0;
      end else if (i_ex_md_req) begin
        state_nxt = RUN;
      end else if (load_use) begin
        o_pc_we      = 1'b0;
        o_ifid_we    = 1'b0;
        o_idex_flush = 1'b1;
      end else if (!i_imem_valid) begin
        o_pc_we      = 1'b0;
        o_ifid_flush = 1'b1;
      end
      // Fetch data in this cycle still belongs to the wrong-path PC.
      if (state == REDIRECT) o_ifid_flush = 1'b1;
    end

    if (!i_resetn) begin
      state_nxt    = RUN;
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_ifid_flush = 1'b0;
      o_idex_we    = 1'b0;
      o_idex_flush = 1'b0;
    end
  end

  assign o_stall = !(o_pc_we && o_ifid_we && o_idex_we);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      o_stall_cnt <= '0;
      o_flush_cnt <= '0;
    end else begin
      if (o_stall)                      o_stall_cnt <= o_stall_cnt + 32'd1;
      if (o_ifid_flush || o_idex_flush) o_flush_cnt <= o_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven bench for pipe_hazard_ctrl with an expected-output scoreboard.
module tb_pipe_hazard_ctrl;

  logic       i_clk = 1'b0;
  logic       i_resetn;
  logic [4:0] i_id_rs1, i_id_rs2, i_ex_rd;
  logic       i_id_use_rs1, i_id_use_rs2;
  logic       i_ex_is_load, i_ex_br_taken, i_ex_md_req, i_md_done, i_imem_valid;
  logic       o_pc_we, o_ifid_we, o_ifid_flush, o_idex_we, o_idex_flush, o_stall;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] o_stall_cnt, o_flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  pipe_hazard_ctrl dut (
    .i_clk         (i_clk),
    .i_resetn      (i_resetn),
    .i_id_rs1      (i_id_rs1),
    .i_id_rs2      (i_id_rs2),
    .i_id_use_rs1  (i_id_use_rs1),
    .i_id_use_rs2  (i_id_use_rs2),
    .i_ex_rd       (i_ex_rd),
    .i_ex_is_load  (i_ex_is_load),
    .i_ex_br_taken (i_ex_br_taken),
    .i_ex_md_req   (i_ex_md_req),
    .i_md_done     (i_md_done),
    .i_imem_valid  (i_imem_valid),
    .o_pc_we       (o_pc_we),
    .o_ifid_we     (o_ifid_we),
    .o_ifid_flush  (o_ifid_flush),
    .o_idex_we     (o_idex_we),
    .o_idex_flush  (o_idex_flush),
    .o_stall       (o_stall)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .o_stall_cnt   (o_stall_cnt),
    .o_flush_cnt   (o_flush_cnt)
`endif
  );

  // expected output bits: {pc_we, ifid_we, ifid_flush, idex_we, idex_flush, stall}
  localparam logic [5:0] E_RST  = 6'b000001;
  localparam logic [5:0] E_NORM = 6'b110100;
  localparam logic [5:0] E_MD   = 6'b000001;
  localparam logic [5:0] E_LU   = 6'b000111;
  localparam logic [5:0] E_IFV  = 6'b011101;
  localparam logic [5:0] E_BR   = 6'b111110;
  localparam logic [5:0] E_RDN  = 6'b111100;
  localparam logic [5:0] E_RDLU = 6'b001111;

  typedef struct {
    string      name;
    logic       resetn;
    logic [4:0] rs1, rs2, ex_rd;
    logic       use1, use2, is_load, br, md_req, md_done, imem_valid;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  exp;
    logic        chk_cnt;
    logic [31:0] exp_stall_cnt;
    logic [31:0] exp_flush_cnt;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[32];

  function automatic vec_t mk(string name, logic rstn, logic [4:0] rs1, logic use1,
                              logic [4:0] rs2, logic use2, logic [4:0] rd, logic ld,
                              logic br, logic mdr, logic mdd, logic iv, logic [5:0] exp);
    vec_t v;
    v.name = name; v.resetn = rstn; v.rs1 = rs1; v.use1 = use1; v.rs2 = rs2; v.use2 = use2;
    v.ex_rd = rd; v.is_load = ld; v.br = br; v.md_req = mdr; v.md_done = mdd;
    v.imem_valid = iv; v.exp = exp;
    return v;
  endfunction

  task automatic drive(input vec_t v, input logic chk_cnt, input logic [31:0] sc,
                       input logic [31:0] fc);
    sb_t e;
    @(posedge i_clk);
    #1;
    i_resetn = v.resetn; i_id_rs1 = v.rs1; i_id_use_rs1 = v.use1; i_id_rs2 = v.rs2;
    i_id_use_rs2 = v.use2; i_ex_rd = v.ex_rd; i_ex_is_load = v.is_load;
    i_ex_br_taken = v.br; i_ex_md_req = v.md_req; i_md_done = v.md_done;
    i_imem_valid = v.imem_valid;
    e.name = v.name; e.exp = v.exp; e.chk_cnt = chk_cnt;
    e.exp_stall_cnt = sc; e.exp_flush_cnt = fc;
    sb_q.push_back(e);
  endtask

  always @(negedge i_clk) begin
    if (sb_q.size() > 0) begin
      sb_t        e;
      logic [5:0] act;
      e   = sb_q.pop_front();
      act = {o_pc_we, o_ifid_we, o_ifid_flush, o_idex_we, o_idex_flush, o_stall};
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.chk_cnt) begin
        total++;
        if (o_stall_cnt !== e.exp_stall_cnt || o_flush_cnt !== e.exp_flush_cnt) begin
          bad++;
          $display("FAIL %s_cnt: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                   e.name, o_stall_cnt, o_flush_cnt, e.exp_stall_cnt, e.exp_flush_cnt);
        end
      end
`endif
    end
  end

  initial begin
    int wait_cyc;
    i_resetn = 1'b0; i_id_rs1 = '0; i_id_rs2 = '0; i_ex_rd = '0;
    i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0; i_ex_is_load = 1'b0;
    i_ex_br_taken = 1'b0; i_ex_md_req = 1'b0; i_md_done = 1'b0; i_imem_valid = 1'b1;

    //                name          rstn rs1 u1 rs2 u2 rd ld br mr md iv exp
    tbl[0]  = mk("reset",         0, 5'd5, 1, 5'd6, 1, 5'd5, 1, 1, 1, 0, 0, E_RST);
    tbl[1]  = mk("no_dep",        1, 5'd6, 1, 5'd7, 1, 5'd5, 1, 0, 0, 0, 1, E_NORM);
    tbl[2]  = mk("lu_rs1",        1, 5'd5, 1, 5'd7, 1, 5'd5, 1, 0, 0, 0, 1, E_LU);
    tbl[3]  = mk("after_lu",      1, 5'd6, 1, 5'd7, 1, 5'd8, 0, 0, 0, 0, 1, E_NORM);
    tbl[4]  = mk("lu_rs2",        1, 5'd1, 0, 5'd9, 1, 5'd9, 1, 0, 0, 0, 1, E_LU);
    tbl[5]  = mk("rs2_unused",    1, 5'd1, 0, 5'd9, 0, 5'd9, 1, 0, 0, 0, 1, E_NORM);
    tbl[6]  = mk("load_x0",       1, 5'd0, 1, 5'd0, 1, 5'd0, 1, 0, 0, 0, 1, E_NORM);
    tbl[7]  = mk("not_load",      1, 5'd4, 1, 5'd4, 1, 5'd4, 0, 0, 0, 0, 1, E_NORM);
    tbl[8]  = mk("imem_inv0",     1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, E_IFV);
    tbl[9]  = mk("imem_inv1",     1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, E_IFV);
    tbl[10] = mk("imem_inv2",     1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, E_IFV);
    tbl[11] = mk("br_plus_lu",    1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 1, E_BR);
    tbl[12] = mk("redirect",      1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_RDN);
    tbl[13] = mk("run_after_rd",  1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_NORM);
    tbl[14] = mk("br",            1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1, 0, 0, 1, E_BR);
    tbl[15] = mk("rd_br_again",   1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1, 0, 0, 1, E_BR);
    tbl[16] = mk("rd_lu",         1, 5'd7, 1, 5'd2, 1, 5'd7, 1, 0, 0, 0, 1, E_RDLU);
    tbl[17] = mk("md_done_now",   1, 5'd7, 1, 5'd2, 1, 5'd7, 1, 0, 1, 1, 1, E_NORM);
    tbl[18] = mk("md_start",      1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 0, 1, E_MD);
    tbl[19] = mk("md_wait1",      1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 0, 1, E_MD);
    tbl[20] = mk("md_wait_br",    1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1, 1, 0, 1, E_MD);
    tbl[21] = mk("md_wait3",      1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 0, 1, E_MD);
    tbl[22] = mk("md_done",       1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 1, 1, E_NORM);
    tbl[23] = mk("br_over_md",    1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1, 1, 0, 1, E_BR);
    tbl[24] = mk("rd_imem_inv",   1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 0, E_IFV);
    tbl[25] = mk("md_over_lu",    1, 5'd5, 1, 5'd2, 1, 5'd5, 1, 0, 1, 0, 1, E_MD);
    tbl[26] = mk("rst_in_mdwait", 0, 5'd5, 1, 5'd2, 1, 5'd5, 1, 0, 1, 0, 1, E_RST);
    tbl[27] = mk("run_after_rst", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1, 1, 0, 1, E_BR);
    tbl[28] = mk("rst_in_redir",  0, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_RST);
    tbl[29] = mk("run_after_rst2",1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_NORM);
    tbl[30] = mk("lu_over_imem",  1, 5'd8, 1, 5'd2, 1, 5'd8, 1, 0, 0, 0, 0, E_LU);
    tbl[31] = mk("tail_norm",     1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_NORM);

    foreach (tbl[i]) drive(tbl[i], 1'b0, 32'd0, 32'd0);

    // mul/div wait of random length, then resume
    begin
      int n;
      n = $urandom_range(1, 6);
      drive(mk("md2_start", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 0, 1, E_MD), 1'b0, 0, 0);
      for (int k = 1; k < n; k++)
        drive(mk("md2_wait", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 0, 1, E_MD), 1'b0, 0, 0);
      drive(mk("md2_done", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 1, 1, 1, E_NORM), 1'b0, 0, 0);
      drive(mk("md2_run", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 1, 0, 0, 1, E_BR), 1'b0, 0, 0);
    end

    // counters: cleared by reset, then five load-use stall cycles
    drive(mk("cnt_rst", 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 1, E_RST), 1'b0, 0, 0);
    drive(mk("cnt_zero", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_NORM), 1'b1, 0, 0);
    for (int k = 0; k < 5; k++)
      drive(mk("cnt_lu", 1, 5'd5, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 1, E_LU), 1'b0, 0, 0);
    drive(mk("cnt_five", 1, 5'd1, 1, 5'd2, 1, 5'd3, 0, 0, 0, 0, 1, E_NORM), 1'b1, 32'd5, 32'd5);

    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 20) begin
      @(posedge i_clk);
      wait_cyc++;
    end
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first (name, direction, width, meaning):
  i_clk  input  1  sole clock, rising edge
  i_resetn  input  1  reset, synchronous, active-low
  i_id_rs1, i_id_rs2  input  5 each  ID-stage source register indices
  i_id_use_rs1, i_id_use_rs2  input  1 each  ID instruction reads rs1/rs2
  i_ex_rd  input  5  EX-stage destination index
  i_ex_is_load  input  1  EX holds a load
  i_ex_br_taken  input  1  EX resolved branch/jump taken (redirect)
  i_ex_md_req  input  1  EX holds a mul/div op
  i_md_done  input  1  mul/div unit result ready this cycle
  i_imem_valid  input  1  instruction fetch data valid this cycle
  o_pc_we  output  1  PC update enable
  o_ifid_we  output  1  IF/ID register write enable
  o_ifid_flush  output  1  IF/ID flush (loads NOP)
  o_idex_we  output  1  ID/EX register write enable
  o_idex_flush  output  1  ID/EX flush (bubble)
  o_stall  output  1  any of pc_we/ifid_we/idex_we deasserted
REQ-002 One clock domain; reset synchronous, active-low, as already decided.

Function
REQ-003 FSM states: RUN, MD_WAIT, REDIRECT; state register only sequential element (plus REQ-014 counters).
REQ-004 Outputs combinational from state and inputs; decisions take effect the same cycle.
REQ-005 Load-use hazard = i_ex_is_load & i_ex_rd!=0 & ((i_id_use_rs1 & i_id_rs1==i_ex_rd) | (i_id_use_rs2 & i_id_rs2==i_ex_rd)).
REQ-006 Priority in RUN and REDIRECT: branch taken > mul/div > load-use > fetch invalid > normal.
REQ-007 Branch taken: pc_we=1, ifid_flush=1, idex_flush=1, ifid_we=1, idex_we=1; next REDIRECT.
REQ-008 i_ex_md_req & !i_md_done: pc_we=0, ifid_we=0, idex_we=0, no flush; next MD_WAIT. i_ex_md_req & i_md_done: normal, stay.
REQ-009 MD_WAIT: pc_we=ifid_we=idex_we=0 until i_md_done=1; that cycle all enables=1, next RUN. i_ex_br_taken ignored in MD_WAIT.
REQ-010 Load-use: pc_we=0, ifid_we=0, idex_we=1, idex_flush=1; state unchanged (one bubble per hazard cycle).
REQ-011 !i_imem_valid: pc_we=0, ifid_flush=1, ifid_we=1, idex_we=1; state unchanged.
REQ-012 Normal: pc_we=ifid_we=idex_we=1, flushes=0.
REQ-013 REDIRECT (one cycle, synchronous imem latency): ifid_flush=1 forced in addition to REQ-006 rules; next RUN unless branch taken again (then REDIRECT).

Reset
REQ-014 While i_resetn=0 at an edge: state<=RUN, counters<=0; in that cycle pc_we=ifid_we=idex_we=0, flushes=0, o_stall=1.
REQ-015 Reset in MD_WAIT or REDIRECT abandons it; first post-reset cycle is RUN.

Configuration
REQ-016 Macro HAZARD_PERF_CNT_EN: when defined, adds outputs o_stall_cnt[31:0] (+1 per cycle o_stall=1 out of reset) and o_flush_cnt[31:0] (+1 per cycle ifid_flush|idex_flush), both wrap 0xFFFFFFFF->0; when undefined, ports and counters absent, other behaviour identical.

Structure
REQ-017 Shared package holds state enum (RUN=2'd0, MD_WAIT=2'd1, REDIRECT=2'd2), NOP encoding 32'h00007013, register index width 5.
REQ-018 Sub-module hazard_detect (pure combinational load-use compare, REQ-005); FSM and counters in top.

Verification
REQ-019 Load x5 in EX, ID add reads rs1=x5 -> one cycle pc_we=0, ifid_we=0, idex_flush=1; next cycle normal.
REQ-020 Load to x0, ID reads x0 -> no stall.
REQ-021 i_ex_md_req=1, i_md_done after 4 cycles -> enables low 4 cycles, high on done cycle, state RUN after.
REQ-022 i_ex_br_taken with simultaneous load-use -> both flushes=1, pc_we=1; next cycle REDIRECT ifid_flush=1; then RUN.
REQ-023 i_imem_valid=0 for 3 cycles -> pc_we=0, ifid_flush=1 each cycle.
REQ-024 Reset asserted mid MD_WAIT -> RUN next cycle; with HAZARD_PERF_CNT_EN counters read 0, 5 stall cycles -> o_stall_cnt=5.
